// File: rtl/qq_op_scheduler.sv
// Two-requester front end for a queue core: round-robin grant, capacity/empty
// checks, one-shot core strobe and held response. Optional QQ_ERR_CNT_EN adds err_cnt_o.
module qq_op_scheduler #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic [1:0]      req_valid_i,
    input  logic [1:0]      req_op_i,
    input  logic [2*W-1:0]  req_data_i,
    output logic [1:0]      req_ready_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [W-1:0]    rsp_data_o,
    output logic            rsp_err_o,
    input  logic [CW-1:0]   array_size_i,
    output logic            q_enq_o,
    output logic            q_deq_o,
    output logic [W-1:0]    q_data_o,
    input  logic            q_done_i,
    input  logic [W-1:0]    q_data_i,
    output logic [CW-1:0]   count_o,
    output logic            busy_o
`ifdef QQ_ERR_CNT_EN
    ,
    output logic [15:0]     err_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic           rr_ptr;
    logic           lat_op;
    logic           lat_id;
    logic [W-1:0]   lat_key;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [CW-1:0]  count;

    logic [1:0]     gnt;
    logic           accept;
    logic           gid;
    logic           gop;
    logic [W-1:0]   gkey;
    logic           rej;

    // Grant is combinational; rr_ptr holds the last winner, so a tie goes to the other side.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE && !reset_i) begin
            if (req_valid_i == 2'b11) gnt = rr_ptr ? 2'b01 : 2'b10;
            else                      gnt = req_valid_i;
        end
    end

    assign accept = |gnt;
    assign gid    = gnt[1];
    assign gop    = gid ? req_op_i[1] : req_op_i[0];
    assign gkey   = gid ? req_data_i[2*W-1:W] : req_data_i[W-1:0];
    // A shrunk capacity below the current count reads as full.
    assign rej    = gop ? (count == '0) : (count >= array_size_i);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = rej ? RESP : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (q_done_i) state_nxt = RESP;
            RESP:  if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            rr_ptr   <= 1'b1;
            lat_op   <= 1'b0;
            lat_id   <= 1'b0;
            lat_key  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                lat_op   <= gop;
                lat_id   <= gid;
                lat_key  <= gkey;
                rr_ptr   <= gid;
                rsp_err  <= rej;
                rsp_data <= '0;
            end
            if (state == WAIT && q_done_i) begin
                if (lat_op) begin
                    rsp_data <= q_data_i;
                    if (count != '0) count <= count - CW'(1);
                end else if (count != '1) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

`ifdef QQ_ERR_CNT_EN
    logic [15:0] err_cnt;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)                                       err_cnt <= '0;
        else if (accept && rej && err_cnt != 16'hFFFF)     err_cnt <= err_cnt + 16'd1;
    end
    assign err_cnt_o = err_cnt;
`endif

    assign req_ready_o = gnt;
    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = lat_id;
    assign rsp_data_o  = rsp_data;
    assign rsp_err_o   = rsp_err;
    assign q_enq_o     = (state == ISSUE) && !lat_op;
    assign q_deq_o     = (state == ISSUE) && lat_op;
    assign q_data_o    = lat_key;
    assign count_o     = count;
    assign busy_o      = (state != IDLE);

endmodule

// File: doc/qq_op_scheduler.md
QQ_OP_SCHEDULER -- requirements
Module: qq_op_scheduler

Interface
REQ-001 SHALL have parameter W, default 32, giving the data word width.
REQ-002 SHALL have parameter CW, default 8, giving the occupancy count width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i, input, 2 bits: per-requester request valid (index 0, 1).
REQ-006 SHALL have port req_op_i, input, 2 bits: per-requester opcode, 0 = enqueue, 1 = dequeue.
REQ-007 SHALL have port req_data_i, input, 2*W bits: per-requester enqueue key; requester n occupies bits [n*W +: W].
REQ-008 SHALL have port req_ready_o, output, 2 bits: per-requester accept strobe.
REQ-009 SHALL have port rsp_valid_o, output, 1 bit: response valid.
REQ-010 SHALL have port rsp_ready_i, input, 1 bit: response consumed.
REQ-011 SHALL have port rsp_id_o, output, 1 bit: requester index of the response.
REQ-012 SHALL have port rsp_data_o, output, W bits: dequeued key; 0 for enqueue and error responses.
REQ-013 SHALL have port rsp_err_o, output, 1 bit: request rejected.
REQ-014 SHALL have port array_size_i, input, CW bits: queue capacity.
REQ-015 SHALL have ports q_enq_o and q_deq_o, output, 1 bit each: single-cycle operation strobes to the queue core.
REQ-016 SHALL have port q_data_o, output, W bits: key driven to the core.
REQ-017 SHALL have port q_done_i, input, 1 bit: core operation complete.
REQ-018 SHALL have port q_data_i, input, W bits: core dequeue result, valid with q_done_i.
REQ-019 SHALL have ports count_o, output, CW bits (current occupancy), and busy_o, output, 1 bit (state not IDLE).

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE, SHALL assert req_ready_o for exactly one valid requester, chosen by round-robin: the requester not granted last wins ties.
REQ-022 SHALL take req_ready_o combinationally from req_valid_i and the round-robin pointer; it SHALL be 0 outside IDLE.
REQ-023 SHALL define acceptance as the cycle in which the valid and ready bits of a requester are both 1.
REQ-024 On acceptance, SHALL latch the opcode, key and requester index, and SHALL update the round-robin pointer to the granted index.
REQ-025 On acceptance of an enqueue with count_o >= array_size_i, SHALL set rsp_err_o=1 and go to RESP, leaving the core untouched.
REQ-026 On acceptance of a dequeue with count_o == 0, SHALL set rsp_err_o=1 and go to RESP, leaving the core untouched.
REQ-027 On acceptance of any other request, SHALL go to ISSUE.
REQ-028 In ISSUE, SHALL assert q_enq_o or q_deq_o for exactly one cycle, with q_data_o equal to the latched key, then go to WAIT.
REQ-029 In WAIT, on q_done_i=1, SHALL capture q_data_i for a dequeue and go to RESP.
REQ-030 In WAIT, on q_done_i=1, SHALL increment count_o for an enqueue and decrement it for a dequeue.
REQ-031 SHALL ignore q_done_i in all states other than WAIT.
REQ-032 In RESP, SHALL hold rsp_valid_o=1 and all response fields stable until rsp_ready_i=1, then return to IDLE.
REQ-033 When rsp_valid_o and rsp_ready_i are both 1, SHALL not accept a new request in that cycle; the earliest next acceptance is the following cycle.
REQ-034 Minimum latency for a successful operation SHALL be: acceptance at cycle T, strobe at T+1, done at T+2 or later, response in the cycle after done.
REQ-035 Minimum latency for a rejected operation SHALL be: acceptance at T, rsp_valid_o=1 at T+1.
REQ-036 SHALL evaluate array_size_i live; a reduced array_size_i below count_o SHALL make the queue read as full and SHALL not alter count_o.
REQ-037 SHALL never wrap count_o.

Reset
REQ-038 While reset_i=1, SHALL immediately force state IDLE, count_o=0, round-robin pointer=1 (so requester 0 wins first), and all outputs to 0.
REQ-039 Reset asserted mid-operation SHALL abandon the latched request with no response issued.

Configuration
REQ-040 With QQ_ERR_CNT_EN defined, SHALL provide output err_cnt_o, 16 bits.
REQ-041 With QQ_ERR_CNT_EN defined, err_cnt_o SHALL increment once per rejected request, saturate at 16'hFFFF, and reset to 0.
REQ-042 Without QQ_ERR_CNT_EN, the err_cnt_o port and its counter SHALL not exist; all other behaviour is unchanged.

Verification
REQ-043 Single enqueue: requester 0 enqueues 32'h10 with array_size_i=4 -> q_enq_o pulses with q_data_o=32'h10; after q_done_i, response id=0, err=0, count_o=1.
REQ-044 Dequeue with data: after the enqueue above, requester 1 dequeues and the core returns 32'h10 -> rsp_data_o=32'h10, count_o=0.
REQ-045 Empty dequeue: dequeue at count_o=0 -> no core strobe, rsp_err_o=1 one cycle after acceptance, rsp_data_o=0; err_cnt_o=1 when QQ_ERR_CNT_EN is defined.
REQ-046 Full and fairness: both requesters hold enqueue valid continuously with array_size_i=2 -> grants alternate 0,1,0,1; the third and fourth responses have rsp_err_o=1; count_o stays 2.
REQ-047 Backpressure and reset: hold rsp_ready_i=0 for 5 cycles -> response fields stay stable; assert reset_i during WAIT -> busy_o=0 and count_o=0 with no clock edge, and no response is issued.
